batch_range_stat: RTL and testbench

- Per-channel mini-batch statistics stage for range batch normalization.
- Accepts a stream of MINI_BATCH signed samples and accumulates their sum, minimum and maximum.
- At end of batch emits the batch mean (avg_out) and the scaled range used as the deviation estimate (var_out), with a one-cycle valid_out pulse.
- Sits directly upstream of the global running-statistics update stage; valid_out/avg_out/var_out drive that stage's valid_in/avg_in/var_in.

---
 rtl/bn_pkg.sv | 34 +++
 rtl/bn_minmax_track.sv | 61 ++++++
 rtl/batch_range_stat.sv | 155 +++++++++++++++
 tb/tb_batch_range_stat.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// -----------------------------------------------------------------------------
// bn_pkg
// Shared definitions for the range batch-normalization statistics blocks.
//   state_t             : controller states of batch_range_stat
//   DEFAULT_*           : default data width, batch size, fractional bits and
//                         range-to-sigma scale factor
//   sum_width/prod_width: widths of the batch accumulator and the scaled-range
//                         product, derived from the data and counter widths
// -----------------------------------------------------------------------------
package bn_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,  // accepting samples
    CALC = 2'd1,  // computing mean and scaled range
    OUT  = 2'd2   // presenting the result pulse
  } state_t;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_MINI_BATCH  = 64;
  localparam int DEFAULT_FRAC_BITS   = 8;
  localparam int DEFAULT_RANGE_SCALE = 89;  // ~ 1/sqrt(2 ln 64) in Q8
  localparam int RANGE_SCALE_WIDTH   = 16;

  // A sum of 2^addr_width signed dw-bit samples fits in dw+addr_width bits.
  function automatic int sum_width(input int dw, input int aw);
    return dw + aw;
  endfunction

  // The range is an unsigned dw+1 bit value multiplied by the scale factor.
  function automatic int prod_width(input int dw);
    return dw + 1 + RANGE_SCALE_WIDTH;
  endfunction

endpackage

// File: rtl/bn_minmax_track.sv
// -----------------------------------------------------------------------------
// bn_minmax_track
// Signed running minimum/maximum over one batch.
//   clk, rst   : clock, synchronous active-high reset (clears to zero)
//   clear      : zero both trackers (has priority over sample_en)
//   sample_en  : a sample is being accepted this cycle
//   first      : the accepted sample is the first of its batch; it loads both
//                min and max instead of being compared against stale values
//   data_in    : signed sample
//   min_val    : running signed minimum
//   max_val    : running signed maximum
// -----------------------------------------------------------------------------
module bn_minmax_track
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         sample_en,
  input  logic                         first,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] min_val,
  output logic signed [DATA_WIDTH-1:0] max_val
);

  logic signed [DATA_WIDTH-1:0] min_reg, min_next;
  logic signed [DATA_WIDTH-1:0] max_reg, max_next;

  always_comb begin
    min_next = min_reg;
    max_next = max_reg;
    if (clear) begin
      min_next = '0;
      max_next = '0;
    end else if (sample_en) begin
      if (first) begin
        min_next = data_in;
        max_next = data_in;
      end else begin
        if (data_in < min_reg) min_next = data_in;
        if (data_in > max_reg) max_next = data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_reg <= '0;
      max_reg <= '0;
    end else begin
      min_reg <= min_next;
      max_reg <= max_next;
    end
  end

  assign min_val = min_reg;
  assign max_val = max_reg;

endmodule

// File: rtl/batch_range_stat.sv
// -----------------------------------------------------------------------------
// batch_range_stat
// Per-channel mini-batch statistics for range batch normalization. Accumulates
// MINI_BATCH signed samples, then emits the batch mean and the scaled range
// (max-min)*RANGE_SCALE >> FRAC_BITS used as the deviation estimate.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : abort the batch being accumulated (ignored while computing)
//   data_valid  : sample valid
//   data_ready  : sample accept; a transfer is data_valid && data_ready
//   data_in     : signed sample
//   valid_out   : one-cycle result pulse
//   avg_out     : signed batch mean (floor), held until the next result
//   var_out     : scaled range, held until the next result
//
// Build option:
//   BATCH_RANGE_SAT_EN : when defined, var_out saturates at the largest
//                        positive value instead of wrapping on overflow.
// -----------------------------------------------------------------------------
module batch_range_stat
  import bn_pkg::*;
#(
  parameter int                           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                           MINI_BATCH  = DEFAULT_MINI_BATCH,
  parameter int                           ADDR_WIDTH  = $clog2(MINI_BATCH),
  parameter int                           FRAC_BITS   = DEFAULT_FRAC_BITS,
  parameter logic [RANGE_SCALE_WIDTH-1:0] RANGE_SCALE = RANGE_SCALE_WIDTH'(DEFAULT_RANGE_SCALE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         data_valid,
  output logic                         data_ready,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] avg_out,
  output logic signed [DATA_WIDTH-1:0] var_out
);

  localparam int SUM_W  = sum_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int PROD_W = prod_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(MINI_BATCH - 1);

  state_t                       state_reg;
  logic [ADDR_WIDTH-1:0]        cnt_reg;
  logic signed [SUM_W-1:0]      sum_reg;
  logic                         ready_reg;
  logic                         valid_reg;
  logic signed [DATA_WIDTH-1:0] avg_reg;
  logic signed [DATA_WIDTH-1:0] var_reg;

  logic                         transfer;
  logic                         track_clear;
  logic signed [DATA_WIDTH-1:0] min_val;
  logic signed [DATA_WIDTH-1:0] max_val;
  logic signed [SUM_W-1:0]      sample_ext;
  logic signed [DATA_WIDTH-1:0] avg_next;
  logic [DATA_WIDTH:0]          range_val;
  logic [PROD_W-1:0]            prod;
  logic [PROD_W-1:0]            prod_scaled;
  logic signed [DATA_WIDTH-1:0] var_next;

  // clear wins over a sample presented in the same cycle.
  assign transfer    = (state_reg == ACC) && data_valid && !clear;
  // The min/max trackers are wiped on a user clear in ACC and again in OUT so
  // every batch starts from a clean slate.
  assign track_clear = ((state_reg == ACC) && clear) || (state_reg == OUT);

  bn_minmax_track #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_minmax (
    .clk       (clk),
    .rst       (rst),
    .clear     (track_clear),
    .sample_en (transfer),
    .first     (cnt_reg == '0),
    .data_in   (data_in),
    .min_val   (min_val),
    .max_val   (max_val)
  );

  assign sample_ext = SUM_W'(data_in);

  // Arithmetic shift floors toward -inf, which is the defined mean rounding.
  assign avg_next = DATA_WIDTH'(sum_reg >>> ADDR_WIDTH);

  // max >= min within a batch, so the one-bit-wider difference is the
  // non-negative range even when it spans the full signed input range.
  assign range_val   = {max_val[DATA_WIDTH-1], max_val} - {min_val[DATA_WIDTH-1], min_val};
  assign prod        = PROD_W'(range_val) * PROD_W'(RANGE_SCALE);
  assign prod_scaled = prod >> FRAC_BITS;

`ifdef BATCH_RANGE_SAT_EN
  localparam logic [DATA_WIDTH-1:0] VAR_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  assign var_next = (prod_scaled > PROD_W'(VAR_MAX)) ? VAR_MAX : DATA_WIDTH'(prod_scaled);
`else
  assign var_next = DATA_WIDTH'(prod_scaled);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ACC;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      avg_reg   <= '0;
      var_reg   <= '0;
    end else begin
      case (state_reg)
        ACC: begin
          valid_reg <= 1'b0;
          if (clear) begin
            cnt_reg <= '0;
            sum_reg <= '0;
          end else if (data_valid) begin
            sum_reg <= sum_reg + sample_ext;
            // MINI_BATCH is a power of two, so the counter wraps to 0 on
            // the last sample by itself.
            cnt_reg <= cnt_reg + ADDR_WIDTH'(1);
            if (cnt_reg == LAST_CNT) begin
              state_reg <= CALC;
              ready_reg <= 1'b0;
            end
          end
        end
        CALC: begin
          avg_reg   <= avg_next;
          var_reg   <= var_next;
          valid_reg <= 1'b1;
          state_reg <= OUT;
        end
        OUT: begin
          valid_reg <= 1'b0;
          sum_reg   <= '0;
          cnt_reg   <= '0;
          ready_reg <= 1'b1;
          state_reg <= ACC;
        end
        default: begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= ACC;
        end
      endcase
    end
  end

  assign data_ready = ready_reg;
  assign valid_out  = valid_reg;
  assign avg_out    = avg_reg;
  assign var_out    = var_reg;

endmodule

// File: tb/tb_batch_range_stat.sv
// -----------------------------------------------------------------------------
// tb_batch_range_stat
// Drives batch_range_stat (default scale 89) and a second instance with scale
// 256 from the same stimulus. Expected batch results are computed from the
// accepted samples with plain arithmetic and queued; a monitor pops and
// compares whenever valid_out pulses.
// -----------------------------------------------------------------------------
module tb_batch_range_stat;

  localparam int DW = 16;
  localparam int MB = 64;

  typedef int iq_t[$];

  typedef struct {
    int          due;
    logic [15:0] avg;
    logic [15:0] v89;
    logic [15:0] v256;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        data_valid;
  logic [15:0] data_in;
  logic        data_ready, data_ready_w;
  logic        valid_out, valid_out_w;
  logic [15:0] avg_out, avg_out_w;
  logic [15:0] var_out, var_out_w;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  int   batch_q[$];
  int   blocked = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  batch_range_stat u_dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .valid_out  (valid_out),
    .avg_out    (avg_out),
    .var_out    (var_out)
  );

  batch_range_stat #(
    .RANGE_SCALE (16'd256)
  ) u_dut_w (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .data_valid (data_valid),
    .data_ready (data_ready_w),
    .data_in    (data_in),
    .valid_out  (valid_out_w),
    .avg_out    (avg_out_w),
    .var_out    (var_out_w)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%h) required=%0d (0x%h) t=%0t",
               name, $signed(act), act, $signed(req), req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] fin_var(input longint v);
`ifdef BATCH_RANGE_SAT_EN
    if (v > 32767) return 16'h7FFF;
`endif
    return v[15:0];
  endfunction

  // Reference: mean is floor(sum / MB), deviation is floor(range*scale/256).
  function automatic exp_t model(input iq_t s, input int due);
    longint sum = 0;
    longint q;
    int     mn = s[0];
    int     mx = s[0];
    exp_t   e;
    foreach (s[i]) begin
      sum += s[i];
      if (s[i] < mn) mn = s[i];
      if (s[i] > mx) mx = s[i];
    end
    if (sum >= 0) q = sum / MB;
    else          q = -((-sum + MB - 1) / MB);
    e.due  = due;
    e.avg  = 16'(q);
    e.v89  = fin_var((longint'(mx - mn) * 89) / 256);
    e.v256 = fin_var(longint'(mx - mn));
    return e;
  endfunction

  function automatic iq_t rep(input int v, input int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(v);
    return q;
  endfunction

  // One clock of stimulus. The bench's own view of the batch decides whether
  // the sample is taken: samples are refused for two cycles after each batch.
  task automatic step(input logic v, input logic [15:0] d, input logic clr, output bit accepted);
    data_valid = v;
    data_in    = d;
    clear      = clr;
    @(negedge clk);
    check("data_ready", {15'd0, data_ready}, {15'd0, blocked == 0});
    check("data_ready_w", {15'd0, data_ready_w}, {15'd0, blocked == 0});
    @(posedge clk);
    accepted = 1'b0;
    if (blocked > 0) begin
      blocked--;
    end else if (clr) begin
      batch_q.delete();
    end else if (v) begin
      accepted = 1'b1;
      batch_q.push_back(int'($signed(d)));
      if (batch_q.size() == MB) begin
        sb.push_back(model(batch_q, edge_cnt + 2));
        batch_q.delete();
        blocked = 2;
      end
    end
    #1;
  endtask

  task automatic send(input iq_t vals, input int valid_pct);
    int idx = 0;
    bit acc;
    while (idx < vals.size()) begin
      step($urandom_range(99) < valid_pct, 16'(vals[idx]), 1'b0, acc);
      if (acc) idx++;
    end
  endtask

  task automatic do_reset(input logic v, input logic [15:0] d);
    rst        = 1'b1;
    data_valid = v;
    data_in    = d;
    clear      = 1'b0;
    @(posedge clk);
    batch_q.delete();
    sb.delete();
    blocked = 0;
    #1;
    rst        = 1'b0;
    data_valid = 1'b0;
    #1;
    check("rst_valid_out", {15'd0, valid_out}, 16'd0);
    check("rst_avg_out", avg_out, 16'd0);
    check("rst_var_out", var_out, 16'd0);
    check("rst_data_ready", {15'd0, data_ready}, 16'd1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out || valid_out_w) begin
        check("valid_pair", {15'd0, valid_out_w}, {15'd0, valid_out});
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=1 required=0 t=%0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("RESULT edge=%0d avg=%0d var=%0d var_w=%0d (exp avg=%0d var=%0d var_w=%0d)",
                   edge_cnt, $signed(avg_out), $signed(var_out), $signed(var_out_w),
                   $signed(e.avg), $signed(e.v89), $signed(e.v256));
          check_int("latency", edge_cnt, e.due);
          check("avg_out", avg_out, e.avg);
          check("var_out", var_out, e.v89);
          check("avg_out_w", avg_out_w, e.avg);
          check("var_out_w", var_out_w, e.v256);
        end
      end else if (sb.size() > 0 && edge_cnt > sb[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_valid actual=0 required=1 due_edge=%0d t=%0t", sb[0].due, $time);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    iq_t q;
    bit  acc;
    rst        = 1'b1;
    clear      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("init_valid_out", {15'd0, valid_out}, 16'd0);
    check("init_avg_out", avg_out, 16'd0);
    check("init_var_out", var_out, 16'd0);
    check("init_data_ready", {15'd0, data_ready}, 16'd1);
    mon_en = 1'b1;

    // Constant, ramp and negative batches back to back with valid always high.
    send(rep(5, MB), 100);
    q.delete();
    for (int i = 0; i < MB; i++) q.push_back(i);
    send(q, 100);
    send(rep(-3, MB), 100);
    q.delete();
    for (int i = 0; i < MB; i++) q.push_back((i % 2 == 0) ? -32768 : 32767);
    send(q, 100);

    // Abort after 10 samples, then a fresh batch.
    send(rep(7, 10), 100);
    step(1'b0, 16'd0, 1'b1, acc);
    send(rep(7, MB), 100);

    // Clear coincident with a sample drops it.
    send(rep(50, 5), 100);
    step(1'b1, 16'd100, 1'b1, acc);
    send(rep(2, MB), 100);

    // Reset mid-batch, then reset during the compute cycle.
    send(rep(9, 40), 100);
    do_reset(1'b1, 16'd9);
    send(rep(2, MB), 100);
    send(rep(11, MB), 100);
    do_reset(1'b1, 16'd11);
    send(rep(2, MB), 100);

    // Randomized batches with gaps, one with an abort partway through.
    for (int b = 0; b < 6; b++) begin
      q.delete();
      for (int i = 0; i < MB; i++) begin
        if (b % 2 == 0) q.push_back(int'($urandom_range(65535)) - 32768);
        else            q.push_back(int'($urandom_range(200)) - 100);
      end
      if (b == 3) begin
        send(rep(int'($urandom_range(1000)), 1 + $urandom_range(30)), 70);
        step(1'b1, 16'($urandom_range(65535)), 1'b1, acc);
      end
      send(q, 70);
    end

    repeat (4) step(1'b0, 16'd0, 1'b0, acc);
    check_int("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
